// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit register, with an optional post-write gap.
// Optional write counter output wr_count is enabled by defining ARB_WRITE_COUNT_EN.
//
// state  | meaning
// IDLE   | accepting requests; grant issued combinationally, register written at next edge
// GAP    | forced idle after a write; requests ignored until cnt reaches zero
module reg_write_arbiter #(
  parameter int N          = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   D,
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     Q,
  output logic                 busy
`ifdef ARB_WRITE_COUNT_EN
  ,
  output logic [15:0]          wr_count
`endif
);

  localparam int PW       = (N > 1) ? $clog2(N) : 1;
  localparam int CW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  ptr_nxt;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  win;
  logic           found;
  logic           wr_en;

  // Search from the highest offset down so the lowest offset from ptr is the last, winning, match.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign ptr_nxt = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  assign wr_en   = (state == S_IDLE) && found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (found && (GAP_CYCLES != 0)) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy comes straight from the state flop, so it is registered by construction.
  always_comb begin
    gnt  = '0;
    busy = (state == S_GAP);
    if (!rst && wr_en) begin
      gnt[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q   <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (wr_en) begin
      Q   <= D[win*WIDTH +: WIDTH];
      ptr <= ptr_nxt;
      cnt <= CW'(GAP_LOAD);
    end else if ((state == S_GAP) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef ARB_WRITE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (wr_en) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: three instances with GAP_CYCLES of 0, 2 and 3.
// wr_count is checked only when ARB_WRITE_COUNT_EN is defined.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_a  [3];
  logic [3:0]  req_a  [3];
  logic [31:0] d_bus;
  logic [3:0]  gnt_a  [3];
  logic [7:0]  q_a    [3];
  logic        busy_a [3];
`ifdef ARB_WRITE_COUNT_EN
  logic [15:0] wc_a   [3];
`endif

  int n_pass;
  int n_fail;
  int n_total;

  reg_write_arbiter #(.N(4), .WIDTH(8), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .D(d_bus),
    .gnt(gnt_a[0]), .Q(q_a[0]), .busy(busy_a[0])
`ifdef ARB_WRITE_COUNT_EN
    , .wr_count(wc_a[0])
`endif
  );

  reg_write_arbiter #(.N(4), .WIDTH(8), .GAP_CYCLES(2)) u_gap2 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .D(d_bus),
    .gnt(gnt_a[1]), .Q(q_a[1]), .busy(busy_a[1])
`ifdef ARB_WRITE_COUNT_EN
    , .wr_count(wc_a[1])
`endif
  );

  reg_write_arbiter #(.N(4), .WIDTH(8), .GAP_CYCLES(3)) u_gap3 (
    .clk(clk), .rst(rst_a[2]), .req(req_a[2]), .D(d_bus),
    .gnt(gnt_a[2]), .Q(q_a[2]), .busy(busy_a[2])
`ifdef ARB_WRITE_COUNT_EN
    , .wr_count(wc_a[2])
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wc(input int u, input logic [15:0] exp);
`ifdef ARB_WRITE_COUNT_EN
    check($sformatf("wr_count[%0d]", u), 32'(wc_a[u]), 32'(exp));
`endif
  endtask

  // One cycle: drive req at the falling edge, check gnt/busy mid-cycle, check Q after the rising edge.
  task automatic step(input int u, input logic [3:0] r, input logic [3:0] eg,
                      input logic eb, input logic [7:0] eq, input string tag);
    @(negedge clk);
    req_a[u] = r;
    #1;
    check({tag, "_gnt"}, 32'(gnt_a[u]), 32'(eg));
    check({tag, "_busy"}, 32'(busy_a[u]), 32'(eb));
    @(posedge clk);
    #1;
    check({tag, "_q"}, 32'(q_a[u]), 32'(eq));
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    clk     = 1'b0;
    d_bus   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1;
      req_a[i] = 4'b0000;
    end
    req_a[0] = 4'b1111;

    // Reset holds gnt low even with every requester asserting
    #12;
    check("rst_gnt", 32'(gnt_a[0]), 32'h0);
    check("rst_q", 32'(q_a[0]), 32'h0);
    check("rst_busy", 32'(busy_a[0]), 32'h0);
    check_wc(0, 16'd0);

    @(posedge clk);
    #1;
    rst_a[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b1111, 4'(1 << (i % 4)), 1'b0, 8'(8'hA0 + (i % 4)), $sformatf("rot%0d", i));
    end
    check_wc(0, 16'd8);

    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0100, 4'b0100, 1'b0, 8'hA2, $sformatf("solo%0d", i));
    end
    check_wc(0, 16'd13);

    // ptr is now 3: an idle cycle holds, then the search wraps 3 -> 0
    step(0, 4'b0000, 4'b0000, 1'b0, 8'hA2, "idle");
    step(0, 4'b0011, 4'b0001, 1'b0, 8'hA0, "wrap0");
    step(0, 4'b0011, 4'b0010, 1'b0, 8'hA1, "wrap1");
    step(0, 4'b0001, 4'b0001, 1'b0, 8'hA0, "wrap2");
    check_wc(0, 16'd16);

    // GAP_CYCLES=2: one grant every third cycle, req noise in GAP ignored
    @(posedge clk);
    #1;
    req_a[1] = 4'b1111;
    rst_a[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b1111, 4'(1 << k), 1'b0, 8'(8'hA0 + k), $sformatf("g2w%0d", k));
      step(1, 4'b0101, 4'b0000, 1'b1, 8'(8'hA0 + k), $sformatf("g2a%0d", k));
      step(1, 4'b0000, 4'b0000, 1'b1, 8'(8'hA0 + k), $sformatf("g2b%0d", k));
    end
    check_wc(1, 16'd4);

    // Withdrawal: req[1] raised and dropped entirely inside GAP
    step(1, 4'b0001, 4'b0001, 1'b0, 8'hA0, "wd_w");
    step(1, 4'b0010, 4'b0000, 1'b1, 8'hA0, "wd_a");
    step(1, 4'b0000, 4'b0000, 1'b1, 8'hA0, "wd_b");
    step(1, 4'b0000, 4'b0000, 1'b0, 8'hA0, "wd_c");
    check_wc(1, 16'd5);

    // GAP_CYCLES=3: reset during the first GAP cycle
    @(posedge clk);
    #1;
    req_a[2] = 4'b0100;
    rst_a[2] = 1'b0;
    step(2, 4'b0100, 4'b0100, 1'b0, 8'hA2, "g3w");
    check("g3_busy_gap", 32'(busy_a[2]), 32'h1);
    check_wc(2, 16'd1);
    #1;
    req_a[2] = 4'b1010;
    rst_a[2] = 1'b1;
    #1;
    check("g3_rst_busy", 32'(busy_a[2]), 32'h0);
    check("g3_rst_q", 32'(q_a[2]), 32'h0);
    check("g3_rst_gnt", 32'(gnt_a[2]), 32'h0);
    check_wc(2, 16'd0);
    @(posedge clk);
    #1;
    rst_a[2] = 1'b0;
    step(2, 4'b1010, 4'b0010, 1'b0, 8'hA1, "g3post");
    check_wc(2, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop register (output Q) between N requesters.
- Round-robin arbitration with a same-cycle grant handshake.
- Optional programmable gap enforces a minimum spacing between writes.
- Sits in front of any shared state register that several producers update.

Parameters:
- N, 4, number of requesters (N >= 2).
- WIDTH, 8, width of the shared register and of each data lane.
- GAP_CYCLES, 0, idle cycles forced after every write (0 = back-to-back writes allowed).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants to write.
- D  input  N*WIDTH  flattened write data; lane i = D[i*WIDTH +: WIDTH].
- gnt  output  N  one-hot grant, combinational, valid in the cycle the write is accepted.
- Q  output  WIDTH  shared register contents.
- busy  output  1  high while in the GAP state.

Behaviour:
- Reset (async, rst=1):
  - Q=0, busy=0, gnt=0 (gnt is forced 0 while rst is high regardless of req).
  - ptr=0, state=IDLE, gap counter=0.
- State machine:
  - Two states, IDLE and GAP.
  - IDLE: if req != 0, the winner w is the first set bit searching ptr, ptr+1, ..., ptr+N-1 mod N.
  - gnt = onehot(w) combinationally in that cycle.
  - At the next rising edge: Q <= D lane w; ptr <= (w+1) mod N.
  - At that same edge: if GAP_CYCLES=0, stay IDLE; else go to GAP and load cnt <= GAP_CYCLES-1.
  - IDLE with req=0: gnt=0, Q and ptr hold.
  - GAP: gnt=0, busy=1, req is ignored and Q holds.
    - If cnt=0, go to IDLE at the next edge; else cnt decrements.
  - busy is registered (high exactly GAP_CYCLES cycles after each write).
- Handshake:
  - A requester holds req[i] and its data lane until it sees gnt[i]=1.
  - The write is completed at the edge ending that cycle.
  - Dropping req[i] before a grant withdraws the request; no write occurs.
  - req[i] still high in the cycle after its grant is a new request.
- Throughput and latency:
  - Write throughput is one per GAP_CYCLES+1 cycles.
  - Latency from grant to Q update is 1 edge.
- Fairness:
  - With all requesters asserting continuously, grants rotate 0,1,...,N-1,0.
  - No requester waits more than (N-1)*(GAP_CYCLES+1) writes' worth of cycles.
- Wrap-around: ptr wraps N-1 -> 0; the search wraps modulo N.
- Reset mid-operation: an in-flight GAP is abandoned immediately; after release the block starts in IDLE with ptr=0.
- Widths: ptr is $clog2(N) bits; cnt is $clog2(GAP_CYCLES+1) bits (minimum 1).

Optional Feature:
- Macro: ARB_WRITE_COUNT_EN.
- Defined:
  - Adds output wr_count (16 bits), reset to 0.
  - wr_count increments by 1 at every edge that updates Q from a grant.
  - Wraps 16'hFFFF -> 16'h0000.
- Undefined: the wr_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with req=4'b1111, lanes D0..D3=8'hA0..8'hA3:
  - While rst=1: gnt=0, Q=0, busy=0.
  - First cycle after release: gnt=4'b0001; after that edge Q=8'hA0.
- All four requesting continuously for 8 cycles (GAP_CYCLES=0):
  - gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
  - Q sequence A0,A1,A2,A3,A0,...
- Only req=4'b0100 held for 5 cycles: gnt=4'b0100 every cycle, Q=8'hA2; a later req=4'b0001 wins next (ptr wrapped to 3 -> 0).
- GAP_CYCLES=2 instance, all requesting:
  - gnt pulses every 3rd cycle in rotation; busy=1 for the 2 cycles after each grant.
  - Q is stable during busy; any req change in GAP produces no gnt.
- Assert rst during the first GAP cycle (GAP_CYCLES=3):
  - busy, Q, gnt go 0 without a clock edge.
  - After release with req=4'b1010: gnt=4'b0010 first (ptr=0).
- Withdrawal: req[1]=1 asserted in GAP, dropped before GAP ends -> no gnt[1], Q unchanged; with ARB_WRITE_COUNT_EN, wr_count unchanged.
